// File: rtl/lego_sa_pkg.sv
// Shared systolic-array defaults and the activation feeder state type.
package lego_sa_pkg;

  localparam int unsigned DATAWIDTH_DEF = 8;
  localparam int unsigned N_SIZE_DEF    = 16;
  localparam int unsigned LEN_W_DEF     = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/act_feeder.sv
// Streams one tile of activation vectors to the skew stage, then drains it with zero vectors.
// Optional ACT_FEEDER_PERF_EN adds a saturating stall counter output.
module act_feeder
  import lego_sa_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
  parameter int unsigned N_SIZE    = N_SIZE_DEF,
  parameter int unsigned LEN_W     = LEN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data [N_SIZE],
  output logic [DATAWIDTH-1:0] act_out [N_SIZE],
  output logic                 act_valid,
  output logic                 busy,
  output logic                 done
`ifdef ACT_FEEDER_PERF_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int unsigned FLUSH_W = (N_SIZE > 2) ? $clog2(N_SIZE - 1) : 1;

  feeder_state_t        state_q, state_d;
  logic [LEN_W-1:0]     vec_cnt_q, vec_cnt_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [FLUSH_W-1:0]   flush_q, flush_d;
  logic [DATAWIDTH-1:0] act_d [N_SIZE];
  logic                 act_valid_d;
  logic                 done_d;
  logic                 busy_d;
  logic                 hs;

  // Acceptance is refused in the abort cycle so a cancelled tile swallows nothing.
  assign in_ready = (state_q == STREAM) && !abort && !rst;
  assign hs       = in_valid && in_ready;

  // Next-state, counters and next output values.
  always_comb begin
    state_d     = state_q;
    vec_cnt_d   = vec_cnt_q;
    len_d       = len_q;
    flush_d     = flush_q;
    act_valid_d = 1'b0;
    for (int i = 0; i < N_SIZE; i++) act_d[i] = '0;

    if (abort) begin
      state_d   = IDLE;
      vec_cnt_d = '0;
      flush_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            vec_cnt_d = '0;
            if (cfg_len != '0) begin
              state_d = STREAM;
              len_d   = cfg_len;
            end else begin
              state_d = DONE;
            end
          end
        end
        STREAM: begin
          if (hs) begin
            act_d       = in_data;
            act_valid_d = 1'b1;
            if (vec_cnt_q == len_q - LEN_W'(1)) begin
              state_d   = FLUSH;
              vec_cnt_d = '0;
              flush_d   = FLUSH_W'(N_SIZE - 2);
            end else begin
              vec_cnt_d = vec_cnt_q + LEN_W'(1);
            end
          end
        end
        FLUSH: begin
          if (flush_q == '0) state_d = DONE;
          else               flush_d = flush_q - FLUSH_W'(1);
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_cnt_q <= '0;
      len_q     <= '0;
      flush_q   <= '0;
      for (int i = 0; i < N_SIZE; i++) act_out[i] <= '0;
      act_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_cnt_q <= vec_cnt_d;
      len_q     <= len_d;
      flush_q   <= flush_d;
      act_out   <= act_d;
      act_valid <= act_valid_d;
      done      <= done_d;
      busy      <= busy_d;
    end
  end

`ifdef ACT_FEEDER_PERF_EN
  // Counts starved STREAM cycles; holds after the tile until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state_q == IDLE) && start && !abort) begin
      stall_cnt <= '0;
    end else if ((state_q == STREAM) && !in_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
